// File: rtl/run_step_ctrl.sv
// Run/stop/single-step sequencer for the 3-phase clock generator; halts only on instruction boundaries.
// Latency: all outputs registered; a halt request takes effect one clk after the next cycle_end.
// Backpressure: none; stop requests are held pending until the next boundary, run/step ignored while active.
module run_step_ctrl #(
    parameter int ADDR_W       = 8,
    parameter int RESET_CYCLES = 4,
    parameter bit START_HALTED = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cycle_end,
    input  logic              run_req,
    input  logic              stop_req,
    input  logic              step_req,
    input  logic [7:0]        step_n,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic              bp_en,
    output logic              halt,
    output logic              core_reset,
    output logic              halted,
    output logic [1:0]        halt_reason,
    output logic [7:0]        steps_left,
    output logic [15:0]       instr_count
);

    localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);

    localparam logic [1:0] REASON_NONE = 2'd0;
    localparam logic [1:0] REASON_STOP = 2'd1;
    localparam logic [1:0] REASON_STEP = 2'd2;
    localparam logic [1:0] REASON_BP   = 2'd3;

    typedef enum logic [1:0] {
        ST_RST,
        ST_HALTED,
        ST_RUN,
        ST_STEP
    } state_t;

    state_t           state;
    logic             stop_pend;
    logic [CNT_W-1:0] rst_cnt;

    logic       bp_hit;
    logic       stop_now;
    logic [7:0] step_load;

    // Boundary decision inputs: breakpoint match, pending-or-fresh stop, clamped step count
    always_comb begin
        bp_hit    = bp_en && (pc == bp_addr);
        stop_now  = stop_pend || stop_req;
        step_load = (step_n == 8'd0) ? 8'd1 : step_n;
    end

    // Controller FSM with all outputs registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RST;
            halt        <= 1'b1;
            core_reset  <= 1'b1;
            halted      <= 1'b0;
            halt_reason <= REASON_NONE;
            steps_left  <= 8'd0;
            instr_count <= 16'd0;
            stop_pend   <= 1'b0;
            rst_cnt     <= '0;
        end else begin
            case (state)
                ST_RST: begin
                    if (rst_cnt == RST_LAST) begin
                        core_reset <= 1'b0;
                        if (START_HALTED) begin
                            state  <= ST_HALTED;
                            halt   <= 1'b1;
                            halted <= 1'b1;
                        end else begin
                            state  <= ST_RUN;
                            halt   <= 1'b0;
                            halted <= 1'b0;
                        end
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end

                ST_HALTED: begin
                    // stop_req wins and simply keeps the core frozen
                    if (stop_req) begin
                        state <= ST_HALTED;
                    end else if (step_req) begin
                        state       <= ST_STEP;
                        steps_left  <= step_load;
                        halt_reason <= REASON_NONE;
                        halt        <= 1'b0;
                        halted      <= 1'b0;
                    end else if (run_req) begin
                        state       <= ST_RUN;
                        halt_reason <= REASON_NONE;
                        halt        <= 1'b0;
                        halted      <= 1'b0;
                    end
                end

                ST_RUN: begin
                    if (cycle_end) begin
                        instr_count <= instr_count + 16'd1;
                        if (bp_hit || stop_now) begin
                            state       <= ST_HALTED;
                            halt        <= 1'b1;
                            halted      <= 1'b1;
                            halt_reason <= bp_hit ? REASON_BP : REASON_STOP;
                            stop_pend   <= 1'b0;
                        end
                    end else if (stop_req) begin
                        stop_pend <= 1'b1;
                    end
                end

                ST_STEP: begin
                    if (cycle_end) begin
                        instr_count <= instr_count + 16'd1;
                        steps_left  <= steps_left - 8'd1;
                        if (bp_hit || stop_now || (steps_left == 8'd1)) begin
                            state     <= ST_HALTED;
                            halt      <= 1'b1;
                            halted    <= 1'b1;
                            stop_pend <= 1'b0;
                            if (bp_hit)
                                halt_reason <= REASON_BP;
                            else if (stop_now)
                                halt_reason <= REASON_STOP;
                            else
                                halt_reason <= REASON_STEP;
                        end
                    end else if (stop_req) begin
                        stop_pend <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_RST;
                    halt  <= 1'b1;
                end
            endcase
        end
    end

endmodule
